// File: rtl/axi_r_buffer_if.sv
// axi_r_buffer_if: descriptor, APB beat and AXI R channel bundle.
// slave = buffer side, master = driver/collector side.
interface axi_r_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic [ID_WIDTH-1:0]   cmd_id_i;
  logic [7:0]            cmd_len_i;
  logic [USER_WIDTH-1:0] cmd_user_i;

  logic                  beat_valid_i;
  logic                  beat_ready_o;
  logic [DATA_WIDTH-1:0] beat_data_i;
  logic                  beat_err_i;

  logic                  master_valid_o;
  logic [DATA_WIDTH-1:0] master_data_o;
  logic [1:0]            master_resp_o;
  logic [ID_WIDTH-1:0]   master_id_o;
  logic [USER_WIDTH-1:0] master_user_o;
  logic                  master_last_o;
  logic                  master_ready_i;

  modport slave (
    input  cmd_valid_i, cmd_id_i,
    input  cmd_len_i, cmd_user_i,
    input  beat_valid_i, beat_data_i,
    input  beat_err_i, master_ready_i,
    output cmd_ready_o, beat_ready_o,
    output master_valid_o, master_data_o,
    output master_resp_o, master_id_o,
    output master_user_o, master_last_o
  );

  modport master (
    output cmd_valid_i, cmd_id_i,
    output cmd_len_i, cmd_user_i,
    output beat_valid_i, beat_data_i,
    output beat_err_i, master_ready_i,
    input  cmd_ready_o, beat_ready_o,
    input  master_valid_o, master_data_o,
    input  master_resp_o, master_id_o,
    input  master_user_o, master_last_o
  );

endinterface

// File: rtl/axi_r_buffer.sv
// axi_r_buffer: AXI2APB read-data return path, beats tagged and queued.
// Optional: AXI_R_ERR_STICKY_EN makes SLVERR sticky for rest of burst.
module axi_r_buffer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  axi_r_buffer_if.slave  bus
);

  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state_q;
  logic [7:0]            cnt_q;
  logic [7:0]            len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;

  logic [DATA_WIDTH-1:0] mem_data [BUFFER_DEPTH];
  logic [ID_WIDTH-1:0]   mem_id   [BUFFER_DEPTH];
  logic [USER_WIDTH-1:0] mem_user [BUFFER_DEPTH];
  logic [1:0]            mem_resp [BUFFER_DEPTH];
  logic                  mem_last [BUFFER_DEPTH];

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  logic       full;
  logic       empty;
  logic       cmd_hs;
  logic       push;
  logic       pop;
  logic       last_beat;
  logic [1:0] resp_d;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    if (p == PW'(BUFFER_DEPTH - 1))
      return '0;
    return p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(BUFFER_DEPTH));
  assign empty = (count_q == '0);

  assign cmd_hs = bus.cmd_valid_i
                & bus.cmd_ready_o;
  assign push   = bus.beat_valid_i
                & bus.beat_ready_o;
  assign pop    = bus.master_valid_o
                & bus.master_ready_i;

  assign last_beat = (cnt_q == len_q);

`ifdef AXI_R_ERR_STICKY_EN
  logic err_q;

  // Sticky burst error: set by any failing beat, cleared per burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (cmd_hs)
      err_q <= 1'b0;
    else if (push && bus.beat_err_i)
      err_q <= 1'b1;
  end

  assign resp_d = (bus.beat_err_i || err_q)
                ? 2'b10 : 2'b00;
`else
  assign resp_d = bus.beat_err_i
                ? 2'b10 : 2'b00;
`endif

  assign bus.cmd_ready_o  = (state_q == IDLE);
  assign bus.beat_ready_o = (state_q == BURST)
                          & ~full;

  // Head entry drives R; forced to zero when empty so reset reads 0.
  assign bus.master_valid_o = ~empty;
  assign bus.master_data_o  = empty ? '0
                            : mem_data[rptr_q];
  assign bus.master_id_o    = empty ? '0
                            : mem_id[rptr_q];
  assign bus.master_user_o  = empty ? '0
                            : mem_user[rptr_q];
  assign bus.master_resp_o  = empty ? '0
                            : mem_resp[rptr_q];
  assign bus.master_last_o  = empty ? 1'b0
                            : mem_last[rptr_q];

  // Burst FSM: latch descriptor, count beats until len.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      id_q    <= '0;
      user_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            state_q <= BURST;
            cnt_q   <= '0;
            len_q   <= bus.cmd_len_i;
            id_q    <= bus.cmd_id_i;
            user_q  <= bus.cmd_user_i;
          end
        end
        BURST: begin
          if (push) begin
            if (last_beat)
              state_q <= IDLE;
            else
              cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; reset drops in-flight entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wptr_q <= nxt(wptr_q);
      if (pop)
        rptr_q <= nxt(rptr_q);
      count_q <= count_q
               + CW'(push)
               - CW'(pop);
    end
  end

  // FIFO storage; contents are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wptr_q] <= bus.beat_data_i;
      mem_id[wptr_q]   <= id_q;
      mem_user[wptr_q] <= user_q;
      mem_resp[wptr_q] <= resp_d;
      mem_last[wptr_q] <= last_beat;
    end
  end

endmodule
